// File: rtl/rob_alloc_ctrl.sv
// ROB allocation/recovery controller: owns tail, shadow head and occupancy,
// grants up to two dispatch slots per cycle and rewinds the tail on mispredict.
module rob_alloc_ctrl #(
  parameter int ROB_NUM     = 64,
  parameter int ROB_SEL     = 6,
  parameter int RECOVER_CYC = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req1_i,
  input  logic               req2_i,
  input  logic [1:0]         commit_cnt_i,
  input  logic               flush_i,
  input  logic [ROB_SEL-1:0] flush_tail_i,
  output logic               grant_o,
  output logic               dp1_o,
  output logic               dp2_o,
  output logic [ROB_SEL-1:0] dp1_addr_o,
  output logic [ROB_SEL-1:0] dp2_addr_o,
  output logic [ROB_SEL-1:0] tail_o,
  output logic [ROB_SEL-1:0] head_o,
  output logic [ROB_SEL:0]   used_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               recovering_o,
  output logic               err_o
);

  typedef enum logic {RUN, RECOVER} state_e;

  state_e             state_q, state_d;
  logic [ROB_SEL-1:0] tail_q, tail_d;
  logic [ROB_SEL-1:0] head_q, head_d;
  logic [ROB_SEL:0]   used_q, used_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [1:0]         n_req;
  logic [1:0]         n_alloc;
  logic               proto_err;
  logic               grant;
  logic [ROB_SEL:0]   free_cnt;
  logic [ROB_SEL:0]   commit_ext;
  logic [ROB_SEL+1:0] used_sum;

  assign commit_ext = {{(ROB_SEL-1){1'b0}}, commit_cnt_i};
  assign n_req      = {1'b0, req1_i} + {1'b0, req2_i};
  assign free_cnt   = (ROB_SEL+1)'(ROB_NUM) - used_q;
  assign proto_err  = (commit_ext > used_q) | (commit_cnt_i == 2'd3) | (req2_i & ~req1_i);

  // Free space comes from the registered count only; same-cycle commits are not bypassed.
  assign grant = (n_req != 2'd0) & (state_q == RUN) & ~flush_i & ~proto_err & ~reset_i
               & (free_cnt >= {{(ROB_SEL-1){1'b0}}, n_req});
  assign n_alloc = grant ? n_req : 2'd0;

  assign grant_o      = grant;
  assign dp1_o        = grant & req1_i;
  assign dp2_o        = grant & req2_i;
  assign dp1_addr_o   = tail_q;
  assign dp2_addr_o   = tail_q + ROB_SEL'(1);
  assign tail_o       = tail_q;
  assign head_o       = head_q;
  assign used_o       = used_q;
  assign full_o       = (used_q == (ROB_SEL+1)'(ROB_NUM));
  assign empty_o      = (used_q == '0);
  assign recovering_o = (state_q == RECOVER);
  assign err_o        = err_q;

  // Signed-safe occupancy update: one extra bit catches underflow on a bad commit.
  assign used_sum = {1'b0, used_q} + {{ROB_SEL{1'b0}}, n_alloc} - {1'b0, commit_ext};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    head_d  = head_q + ROB_SEL'(commit_cnt_i);
    used_d  = used_q;
    err_d   = err_q | proto_err;

    if (flush_i) begin
      tail_d  = flush_tail_i;
      used_d  = {1'b0, flush_tail_i - head_d};
      state_d = RECOVER;
      cnt_d   = 4'(RECOVER_CYC);
    end else begin
      tail_d = tail_q + ROB_SEL'(n_alloc);
      used_d = used_sum[ROB_SEL+1] ? '0 : used_sum[ROB_SEL:0];
      unique case (state_q)
        RUN: begin
          state_d = RUN;
        end
        RECOVER: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tail_q  <= '0;
      head_q  <= '0;
      used_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      head_q  <= head_d;
      used_q  <= used_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed + randomized bench for rob_alloc_ctrl against an arithmetic occupancy model.
module tb_rob_alloc_ctrl;
  localparam int N   = 64;
  localparam int SEL = 6;
  localparam int RC  = 2;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           req1_i = 1'b0;
  logic           req2_i = 1'b0;
  logic [1:0]     commit_cnt_i = 2'd0;
  logic           flush_i = 1'b0;
  logic [SEL-1:0] flush_tail_i = '0;
  logic           grant_o, dp1_o, dp2_o, full_o, empty_o, recovering_o, err_o;
  logic [SEL-1:0] dp1_addr_o, dp2_addr_o, tail_o, head_o;
  logic [SEL:0]   used_o;

  rob_alloc_ctrl #(.ROB_NUM(N), .ROB_SEL(SEL), .RECOVER_CYC(RC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req1_i(req1_i), .req2_i(req2_i),
    .commit_cnt_i(commit_cnt_i), .flush_i(flush_i), .flush_tail_i(flush_tail_i),
    .grant_o(grant_o), .dp1_o(dp1_o), .dp2_o(dp2_o),
    .dp1_addr_o(dp1_addr_o), .dp2_addr_o(dp2_addr_o),
    .tail_o(tail_o), .head_o(head_o), .used_o(used_o),
    .full_o(full_o), .empty_o(empty_o), .recovering_o(recovering_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pointers and count as plain integers, recovery as cycles remaining.
  int m_tail, m_head, m_used, m_rec, m_err;
  int m_nreq;
  bit m_gnt, m_errnow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tail = 0; m_head = 0; m_used = 0; m_rec = 0; m_err = 0;
  endtask

  task automatic check_all();
    m_nreq   = int'(req1_i) + int'(req2_i);
    m_errnow = (int'(commit_cnt_i) > m_used) || (commit_cnt_i == 2'd3) || (req2_i && !req1_i);
    m_gnt    = !reset_i && m_nreq != 0 && m_rec == 0 && !flush_i && (N - m_used >= m_nreq) && !m_errnow;
    chk("grant", 32'(grant_o), 32'(m_gnt));
    chk("dp1", 32'(dp1_o), 32'(m_gnt && req1_i));
    chk("dp2", 32'(dp2_o), 32'(m_gnt && req2_i));
    chk("dp1_addr", 32'(dp1_addr_o), m_tail);
    chk("dp2_addr", 32'(dp2_addr_o), (m_tail + 1) % N);
    chk("tail", 32'(tail_o), m_tail);
    chk("head", 32'(head_o), m_head);
    chk("used", 32'(used_o), m_used);
    chk("full", 32'(full_o), 32'(m_used == N));
    chk("empty", 32'(empty_o), 32'(m_used == 0));
    chk("recovering", 32'(recovering_o), 32'(m_rec != 0));
    chk("err", 32'(err_o), m_err);
  endtask

  task automatic model_update();
    int hn;
    int nalloc;
    if (m_errnow) m_err = 1;
    hn = (m_head + int'(commit_cnt_i)) % N;
    if (flush_i) begin
      m_tail = int'(flush_tail_i);
      m_used = (int'(flush_tail_i) - hn + N) % N;
      m_rec  = RC;
    end else begin
      nalloc = m_gnt ? m_nreq : 0;
      m_tail = (m_tail + nalloc) % N;
      m_used = m_used + nalloc - int'(commit_cnt_i);
      if (m_used < 0) m_used = 0;
      if (m_rec > 0) m_rec--;
    end
    m_head = hn;
  endtask

  // Inputs change at negedge, everything is checked 1 time unit later, state advances at posedge.
  task automatic step(input logic r1, input logic r2, input logic [1:0] cc,
                      input logic fl, input logic [SEL-1:0] ft);
    req1_i = r1; req2_i = r2; commit_cnt_i = cc; flush_i = fl; flush_tail_i = ft;
    #1;
    check_all();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    req1_i = 0; req2_i = 0; commit_cnt_i = 0; flush_i = 0;
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
  endtask

  initial begin
    int lim;
    int k;
    logic r1, r2, fl;
    logic [1:0] cc;
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b0;

    // Reset state, then three double dispatches
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    chk("tail_after3", 32'(tail_o), 6);

    // Fill to 63, refuse a partial double, then wrap to full
    for (int i = 0; i < 28; i++) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // head=10, tail=20, then flush to 15 with a commit
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 2, 0, 0);
    step(0, 0, 1, 1, 6'd15);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Back-to-back flushes restart the recovery window
    step(0, 0, 0, 1, 6'd15);
    step(0, 0, 0, 1, 6'd12);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Over-commit sets the sticky error and clamps occupancy
    step(0, 0, 2, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Asynchronous reset mid-cycle, checked before the next edge
    req1_i = 1; req2_i = 1; commit_cnt_i = 0; flush_i = 0;
    #2 reset_i = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk_i);
    reset_i = 1'b0;

    // Randomized legal traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      r1  = ($urandom % 4) != 0;
      r2  = r1 && ($urandom % 2);
      lim = (m_used < 2) ? m_used : 2;
      cc  = 2'($urandom_range(0, lim));
      fl  = ($urandom % 16) == 0;
      k   = int'($urandom_range(0, N - 1));
      step(r1, r2, cc, fl, SEL'((m_head + int'(cc) + k) % N));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
